tea_cpu_p: RTL and testbench
============================

Name: tea_cpu_p

Overview:
- Parametrised next-generation two-phase accumulator microcontroller for the TEA engine.
- Executes 1+DATA_WIDTH-bit instructions from an external instruction ROM, with a banked register file, an I/O space and a hardware call stack.
- Generalised widths and stack depth. Adds an I/O wait handshake, stack overflow/underflow fault detection, a zero flag and a HALT instruction.

Parameters:
- DATA_WIDTH, 8: accumulator/register/IO data width; must be ≥8.
- PC_WIDTH, 10: program counter width.
- REG_AW, 5: register file address width; must be ≤5 and ≤ DATA_WIDTH-3.
- STACK_AW, 4: call stack holds 2**STACK_AW return addresses.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- instr_addr  out  PC_WIDTH  instruction fetch address (equals pc).
- instr  in  DATA_WIDTH+1  instruction word; combinational from instr_addr, valid by phase 1.
- io_addr  out  5  I/O address (instr[4:0]).
- io_rd  out  1  I/O read strobe.
- io_wr  out  1  I/O write strobe.
- io_wrdata  out  DATA_WIDTH  I/O write data (acc).
- io_rddata  in  DATA_WIDTH  I/O read data, sampled when io_rd && io_ready.
- io_ready  in  1  I/O access complete.
- halted  out  1  core stopped by HALT or fault.
- fault  out  2  bit0 = stack overflow, bit1 = stack underflow; sticky until reset.
- zero  out  1  acc == 0 after the last executed ALU/load/imm instruction.

Behaviour:
- Reset (async, rst=1): pc=0, phase=0, acc=0, cy=0, zero=0, sp=0, reg_off=0, io_prefix=0, halted=0, fault=0, io_rd=io_wr=0. Register file and stack RAM are not reset.
- Phase toggles every clock; phase 0 = decode, phase 1 = execute. pc, acc, cy, sp, reg_off and io_prefix update only on the phase-1 edge. Nominal CPI = 2 clocks.
- Let D = DATA_WIDTH. instr[D]=1 is IMM: acc <= instr[D-1:0], cy unchanged.
- instr[D]=0 takes op = instr[D-1:D-3] and register address ra = reg_off + instr[REG_AW-1:0], modulo 2**REG_AW.
- op 0 ADDC: {cy,acc} <= acc + r + cy.
- op 1 SUBC: {cy,acc} <= acc - r - cy; cy = borrow.
- op 2 AND, op 3 OR, op 6 XOR: cy unchanged.
- op 4 STORE: r <= acc. If ra is all-ones, reg_off <= acc[REG_AW-1:0] instead of the register write.
- op 5 LOAD: acc <= r.
- op 7 subcodes on instr[4:0]:
  - 0x00 SL1: {cy,acc} <= {acc,cy}.
  - 0x10 SR1: {acc,cy} <= {cy,acc}.
  - 0x01 CALL; 0x11/0x19 CALLC/CALLNC.
  - 0x02 JMP; 0x12/0x1A JMPC/JMPNC.
  - 0x03 RET; 0x13/0x1B RETC/RETNC.
  - 0x04 IOOP prefix.
  - 0x14 CLRC.
  - 0x05 HALT.
  - Other subcodes are NOP.
- Conditional branch/call/return is taken when cy ^ instr[3] = 1.
- Jump/call target = pc + sign-extended acc, modulo 2**PC_WIDTH. Not taken: pc+1.
- CALL pushes pc+1 to stack[sp] and sets sp <= sp+1. RET pops: pc <= stack[sp-1], sp <= sp-1.
- Stack limits:
  - Push with sp == 2**STACK_AW - 1: fault[0]=1, halted=1, no write, pc holds.
  - Pop with sp == 0: fault[1]=1, halted=1, pc holds.
- IOOP sets io_prefix for the next instruction only.
- Prefixed LOAD/STORE drives io_rd/io_wr high during that instruction's phase 1 and stalls until io_ready=1:
  - phase stays 1; pc, acc and the prefix hold.
  - On the io_ready edge: LOAD takes acc <= io_rddata; STORE completes; phase -> 0.
  - A prefixed STORE never writes the register file.
- HALT or a fault: halted=1, phase freezes at 0, strobes low. Only reset exits.
- zero updates on IMM, LOAD and ops 0-3/6 and SL1/SR1; otherwise it holds.

Test Plan:
- Reset mid-stall: assert rst while io_rd is waiting on io_ready -> all outputs return to reset values immediately; after release the first fetch is instr_addr=0.
- IMM 0xFF, STORE r2, IMM 0x01, ADDC r2 -> acc=0x00, cy=1, zero=1; pc advances every 2 clocks.
- IMM 0x05, CALL at pc=0x010 -> pc=0x015, sp=1. RET -> pc=0x011, sp=0. RETNC with cy=0 at sp=0 -> fault=2'b10, halted=1.
- Push 2**STACK_AW - 1 CALLs, then one more -> fault=2'b01, halted=1, pc frozen.
- IOOP, LOAD io 3, with io_ready held low 5 clocks then high with io_rddata=0xA5 -> io_rd high 6 clocks, acc=0xA5, io_rd drops.
- IMM 0x1F, STORE r31 (sets reg_off=0x1F), IMM 0x3C, STORE r1 -> physical r0 = 0x3C; JMPC with cy=0 and acc=0xFE is not taken, pc+1.

Source files
------------

// File: rtl/tea_cpu_p.sv
// TEA two-phase accumulator core: decode on phase 0, execute on phase 1.
// Banked register file, prefixed I/O with ready handshake, bounded call stack.
module tea_cpu_p #(
  parameter int DATA_WIDTH = 8,
  parameter int PC_WIDTH   = 10,
  parameter int REG_AW     = 5,
  parameter int STACK_AW   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [PC_WIDTH-1:0]   instr_addr,
  input  logic [DATA_WIDTH:0]   instr,
  output logic [4:0]            io_addr,
  output logic                  io_rd,
  output logic                  io_wr,
  output logic [DATA_WIDTH-1:0] io_wrdata,
  input  logic [DATA_WIDTH-1:0] io_rddata,
  input  logic                  io_ready,
  output logic                  halted,
  output logic [1:0]            fault,
  output logic                  zero
);
  localparam int D  = DATA_WIDTH;
  localparam int TW = (PC_WIDTH > D) ? PC_WIDTH : D;

  typedef enum logic [1:0] {ST_DECODE, ST_EXEC, ST_HALT} state_t;
  state_t state, state_nxt;

  logic [PC_WIDTH-1:0] pc, pc_nxt, pc_inc, target;
  logic [D-1:0]        acc, acc_nxt, rv;
  logic                cy, cy_nxt, zero_nxt, zero_upd, io_prefix, io_prefix_nxt;
  logic [STACK_AW-1:0] sp, sp_nxt, sp_dec;
  logic [REG_AW-1:0]   reg_off, reg_off_nxt, ra;
  logic [1:0]          fault_nxt;
  logic                rf_we, stk_we;
  logic [D-1:0]        rf  [2**REG_AW];
  logic [PC_WIDTH-1:0] stk [2**STACK_AW];
  logic                imm, take, io_op, io_wait;
  logic [2:0]          op;
  logic [4:0]          sub;
  logic [D:0]          sum;
  logic [TW-1:0]       acc_ext;

  assign imm     = instr[D];
  assign op      = instr[D-1:D-3];
  assign sub     = instr[4:0];
  assign ra      = reg_off + instr[REG_AW-1:0];
  assign rv      = rf[ra];
  assign pc_inc  = pc + PC_WIDTH'(1);
  assign sp_dec  = sp - STACK_AW'(1);
  assign acc_ext = TW'($signed(acc));
  assign target  = pc + acc_ext[PC_WIDTH-1:0];
  // Unconditional forms have sub[4]=0; conditional forms test cy against sub[3].
  assign take    = !sub[4] || (cy ^ sub[3]);
  assign io_op   = io_prefix && !imm && (op == 3'd4 || op == 3'd5);
  assign io_wait = io_op && !io_ready;

  assign instr_addr = pc;
  assign io_addr    = instr[4:0];
  assign io_wrdata  = acc;
  assign io_rd      = (state == ST_EXEC) && io_op && (op == 3'd5);
  assign io_wr      = (state == ST_EXEC) && io_op && (op == 3'd4);
  assign halted     = (state == ST_HALT);

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    acc_nxt       = acc;
    cy_nxt        = cy;
    zero_nxt      = zero;
    zero_upd      = 1'b0;
    sp_nxt        = sp;
    reg_off_nxt   = reg_off;
    io_prefix_nxt = io_prefix;
    fault_nxt     = fault;
    rf_we         = 1'b0;
    stk_we        = 1'b0;
    sum           = '0;
    case (state)
      ST_DECODE: state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (!io_wait) begin
          state_nxt     = ST_DECODE;
          pc_nxt        = pc_inc;
          io_prefix_nxt = 1'b0;
          if (imm) begin
            acc_nxt  = instr[D-1:0];
            zero_upd = 1'b1;
          end else begin
            case (op)
              3'd0: begin
                sum = {1'b0, acc} + {1'b0, rv} + (D+1)'(cy);
                {cy_nxt, acc_nxt} = sum;
                zero_upd = 1'b1;
              end
              3'd1: begin
                sum = {1'b0, acc} - {1'b0, rv} - (D+1)'(cy);
                {cy_nxt, acc_nxt} = sum;
                zero_upd = 1'b1;
              end
              3'd2: begin acc_nxt = acc & rv; zero_upd = 1'b1; end
              3'd3: begin acc_nxt = acc | rv; zero_upd = 1'b1; end
              3'd6: begin acc_nxt = acc ^ rv; zero_upd = 1'b1; end
              3'd4: begin
                // The all-ones bank slot is the bank-offset register, not storage.
                if (!io_prefix) begin
                  if (&ra) reg_off_nxt = acc[REG_AW-1:0];
                  else     rf_we = 1'b1;
                end
              end
              3'd5: begin
                acc_nxt  = io_prefix ? io_rddata : rv;
                zero_upd = 1'b1;
              end
              default: begin
                case (sub)
                  5'h00: begin {cy_nxt, acc_nxt} = {acc, cy}; zero_upd = 1'b1; end
                  5'h10: begin {acc_nxt, cy_nxt} = {cy, acc}; zero_upd = 1'b1; end
                  5'h01, 5'h11, 5'h19: begin
                    if (take) begin
                      if (&sp) begin
                        fault_nxt[0] = 1'b1;
                        state_nxt    = ST_HALT;
                        pc_nxt       = pc;
                      end else begin
                        stk_we = 1'b1;
                        sp_nxt = sp + STACK_AW'(1);
                        pc_nxt = target;
                      end
                    end
                  end
                  5'h02, 5'h12, 5'h1A: if (take) pc_nxt = target;
                  5'h03, 5'h13, 5'h1B: begin
                    if (take) begin
                      if (sp == '0) begin
                        fault_nxt[1] = 1'b1;
                        state_nxt    = ST_HALT;
                        pc_nxt       = pc;
                      end else begin
                        sp_nxt = sp_dec;
                        pc_nxt = stk[sp_dec];
                      end
                    end
                  end
                  5'h04: io_prefix_nxt = 1'b1;
                  5'h14: cy_nxt = 1'b0;
                  5'h05: begin state_nxt = ST_HALT; pc_nxt = pc; end
                  default: ;
                endcase
              end
            endcase
          end
          if (zero_upd) zero_nxt = (acc_nxt == '0);
        end
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_DECODE;
      pc        <= '0;
      acc       <= '0;
      cy        <= 1'b0;
      zero      <= 1'b0;
      sp        <= '0;
      reg_off   <= '0;
      io_prefix <= 1'b0;
      fault     <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      acc       <= acc_nxt;
      cy        <= cy_nxt;
      zero      <= zero_nxt;
      sp        <= sp_nxt;
      reg_off   <= reg_off_nxt;
      io_prefix <= io_prefix_nxt;
      fault     <= fault_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rf_we)  rf[ra]  <= acc;
    if (stk_we) stk[sp] <= pc_inc;
  end
endmodule

// File: tb/tb_tea_cpu_p.sv
// Bench for tea_cpu_p: directed scenarios plus random programs generated
// on the fly and checked against an instruction-level model.
module tb_tea_cpu_p;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] instr_addr;
  logic [8:0] instr;
  logic [4:0] io_addr;
  logic       io_rd, io_wr, io_ready, halted, zero;
  logic [7:0] io_wrdata, io_rddata;
  logic [1:0] fault;

  logic [8:0] rom [1024];
  assign instr = rom[instr_addr];

  tea_cpu_p dut (
    .clk(clk), .rst(rst), .instr_addr(instr_addr), .instr(instr),
    .io_addr(io_addr), .io_rd(io_rd), .io_wr(io_wr), .io_wrdata(io_wrdata),
    .io_rddata(io_rddata), .io_ready(io_ready), .halted(halted),
    .fault(fault), .zero(zero)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // instruction-level model state
  logic [9:0] m_pc;
  logic [7:0] m_acc;
  bit         m_cy, m_zero, m_pre, m_halt;
  logic [1:0] m_fault;
  int         m_sp;
  logic [4:0] m_roff;
  logic [7:0] m_rf [32];
  bit         m_valid [32];
  logic [9:0] m_stk [16];

  logic [4:0] sys_tab [15] = '{5'h00, 5'h10, 5'h01, 5'h11, 5'h19, 5'h02, 5'h12,
                               5'h1A, 5'h03, 5'h13, 5'h1B, 5'h04, 5'h14, 5'h06, 5'h1F};

  function automatic logic [8:0] f_imm(input logic [7:0] v); return {1'b1, v}; endfunction
  function automatic logic [8:0] f_op(input logic [2:0] o, input logic [4:0] r); return {1'b0, o, r}; endfunction
  function automatic logic [8:0] f_sys(input logic [4:0] s); return {1'b0, 3'd7, s}; endfunction

  task automatic model_reset();
    m_pc = '0; m_acc = '0; m_cy = 0; m_zero = 0; m_pre = 0; m_halt = 0;
    m_fault = '0; m_sp = 0; m_roff = '0;
  endtask

  task automatic model_exec(input logic [8:0] ins, input logic [7:0] iod);
    int t, s, npc, tgt;
    bit pre, upd, tk;
    logic [2:0] op;
    logic [4:0] sub, ra;
    if (m_halt) return;
    pre = m_pre; m_pre = 0; upd = 0;
    op = ins[7:5]; sub = ins[4:0]; ra = m_roff + ins[4:0];
    npc = (int'(m_pc) + 1) % 1024;
    s = (m_acc >= 8'd128) ? int'(m_acc) - 256 : int'(m_acc);
    tgt = (int'(m_pc) + s + 1024) % 1024;
    tk = (sub[4] == 1'b0) || (m_cy != sub[3]);
    if (ins[8]) begin
      m_acc = ins[7:0]; upd = 1;
    end else begin
      case (op)
        3'd0: begin t = int'(m_acc) + int'(m_rf[ra]) + int'(m_cy); m_cy = (t > 255); m_acc = 8'(t); upd = 1; end
        3'd1: begin t = int'(m_acc) - int'(m_rf[ra]) - int'(m_cy); m_cy = (t < 0); m_acc = 8'(t); upd = 1; end
        3'd2: begin m_acc = m_acc & m_rf[ra]; upd = 1; end
        3'd3: begin m_acc = m_acc | m_rf[ra]; upd = 1; end
        3'd6: begin m_acc = m_acc ^ m_rf[ra]; upd = 1; end
        3'd4: if (!pre) begin
          if (ra == 5'd31) m_roff = m_acc[4:0];
          else begin m_rf[ra] = m_acc; m_valid[ra] = 1; end
        end
        3'd5: begin m_acc = pre ? iod : m_rf[ra]; upd = 1; end
        default: case (sub)
          5'h00: begin t = int'(m_acc) * 2 + int'(m_cy); m_cy = (t > 255); m_acc = 8'(t); upd = 1; end
          5'h10: begin t = int'(m_acc) % 2; m_acc = (m_acc >> 1) | (m_cy ? 8'h80 : 8'h00); m_cy = (t == 1); upd = 1; end
          5'h01, 5'h11, 5'h19: if (tk) begin
            if (m_sp == 15) begin m_fault[0] = 1; m_halt = 1; end
            else begin m_stk[m_sp] = 10'(npc); m_sp++; npc = tgt; end
          end
          5'h02, 5'h12, 5'h1A: if (tk) npc = tgt;
          5'h03, 5'h13, 5'h1B: if (tk) begin
            if (m_sp == 0) begin m_fault[1] = 1; m_halt = 1; end
            else begin m_sp--; npc = int'(m_stk[m_sp]); end
          end
          5'h04: m_pre = 1;
          5'h14: m_cy = 0;
          5'h05: m_halt = 1;
          default: ;
        endcase
      endcase
    end
    if (m_halt) npc = int'(m_pc);
    m_pc = 10'(npc);
    if (upd) m_zero = (m_acc == 8'h00);
  endtask

  task automatic apply_reset();
    rst = 1'b1; io_ready = 1'b0; io_rddata = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Runs one instruction from the decode phase; I/O accesses get wn not-ready cycles.
  task automatic exec_instr(input logic [8:0] ins, input int wn, input logic [7:0] rdata,
                            output int rd_cnt, output int wr_cnt, output logic [4:0] ad);
    bit io_exp;
    io_exp = m_pre && !ins[8] && (ins[7:5] == 3'd4 || ins[7:5] == 3'd5);
    rom[m_pc] = ins; rd_cnt = 0; wr_cnt = 0; io_ready = 1'b0; io_rddata = '0;
    @(posedge clk); #1;
    ad = io_addr;
    if (io_exp)
      for (int i = 0; i < wn; i++) begin
        rd_cnt += int'(io_rd); wr_cnt += int'(io_wr);
        @(posedge clk); #1;
      end
    rd_cnt += int'(io_rd); wr_cnt += int'(io_wr);
    io_ready = 1'b1; io_rddata = rdata;
    @(posedge clk); #1;
    io_ready = 1'b0;
    model_exec(ins, rdata);
  endtask

  task automatic run(input logic [8:0] ins);
    int r, w; logic [4:0] a;
    exec_instr(ins, 0, 8'h00, r, w, a);
  endtask

  task automatic test_reset();
    #1;
    total++; if (instr_addr !== 10'd0 || io_wrdata !== 8'd0 || zero !== 1'b0) begin bad++; $display("FAIL reset_init pc=%h acc=%h zero=%b want 0", instr_addr, io_wrdata, zero); end
    total++; if (halted !== 1'b0 || fault !== 2'b00 || io_rd !== 1'b0 || io_wr !== 1'b0) begin bad++; $display("FAIL reset_flags halted=%b fault=%b rd=%b wr=%b want 0", halted, fault, io_rd, io_wr); end
    apply_reset();
    run(f_imm(8'h5A));
    run(f_sys(5'h04));
    rom[m_pc] = f_op(3'd5, 5'd3);
    io_ready = 1'b0;
    @(posedge clk); #1;
    total++; if (io_rd !== 1'b1) begin bad++; $display("FAIL stall_rd io_rd=%b want 1", io_rd); end
    repeat (2) @(posedge clk);
    #1;
    total++; if (io_rd !== 1'b1 || instr_addr !== 10'd2) begin bad++; $display("FAIL stall_hold io_rd=%b pc=%h want 1/002", io_rd, instr_addr); end
    rst = 1'b1; #1;
    total++; if (io_rd !== 1'b0 || instr_addr !== 10'd0 || io_wrdata !== 8'd0) begin bad++; $display("FAIL reset_async rd=%b pc=%h acc=%h want 0", io_rd, instr_addr, io_wrdata); end
    total++; if (halted !== 1'b0 || fault !== 2'b00 || zero !== 1'b0 || io_wr !== 1'b0) begin bad++; $display("FAIL reset_async_flags h=%b f=%b z=%b wr=%b want 0", halted, fault, zero, io_wr); end
    @(posedge clk); #1;
    rst = 1'b0; model_reset();
    rom[0] = f_imm(8'h00);
    @(posedge clk); #1;
    total++; if (instr_addr !== 10'd0) begin bad++; $display("FAIL first_fetch pc=%h want 000", instr_addr); end
  endtask

  task automatic test_addc();
    logic [8:0] prog [4];
    prog = '{f_imm(8'hFF), f_op(3'd4, 5'd2), f_imm(8'h01), f_op(3'd0, 5'd2)};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      run(prog[i]);
      total++; if (instr_addr !== 10'(i + 1)) begin bad++; $display("FAIL addc_pc step=%0d pc=%h want %h", i, instr_addr, 10'(i + 1)); end
    end
    total++; if (io_wrdata !== 8'h00 || zero !== 1'b1) begin bad++; $display("FAIL addc_result acc=%h zero=%b want 00/1", io_wrdata, zero); end
    run(f_sys(5'h00));
    total++; if (io_wrdata !== 8'h01 || zero !== 1'b0) begin bad++; $display("FAIL addc_carry acc=%h zero=%b want 01/0", io_wrdata, zero); end
  endtask

  task automatic test_call_ret();
    apply_reset();
    for (int i = 0; i < 15; i++) run(f_sys(5'h06));
    run(f_imm(8'h05));
    run(f_sys(5'h01));
    total++; if (instr_addr !== 10'h015) begin bad++; $display("FAIL call_target pc=%h want 015", instr_addr); end
    run(f_sys(5'h03));
    total++; if (instr_addr !== 10'h011) begin bad++; $display("FAIL ret_target pc=%h want 011", instr_addr); end
    run(f_sys(5'h1B));
    repeat (3) @(posedge clk);
    #1;
    total++; if (fault !== 2'b10 || halted !== 1'b1 || instr_addr !== 10'h011) begin bad++; $display("FAIL underflow fault=%b halted=%b pc=%h want 10/1/011", fault, halted, instr_addr); end
  endtask

  task automatic test_overflow();
    apply_reset();
    run(f_imm(8'h01));
    for (int i = 0; i < 15; i++) run(f_sys(5'h01));
    total++; if (instr_addr !== 10'd16 || halted !== 1'b0) begin bad++; $display("FAIL deep_calls pc=%h halted=%b want 010/0", instr_addr, halted); end
    run(f_sys(5'h01));
    repeat (4) @(posedge clk);
    #1;
    total++; if (fault !== 2'b01 || halted !== 1'b1 || instr_addr !== 10'd16) begin bad++; $display("FAIL overflow fault=%b halted=%b pc=%h want 01/1/010", fault, halted, instr_addr); end
  endtask

  task automatic test_io();
    int r, w; logic [4:0] a;
    apply_reset();
    run(f_imm(8'h77));
    run(f_op(3'd4, 5'd3));
    run(f_sys(5'h04));
    exec_instr(f_op(3'd5, 5'd3), 5, 8'hA5, r, w, a);
    total++; if (r !== 6 || w !== 0 || a !== 5'd3) begin bad++; $display("FAIL io_load rd_cycles=%0d wr_cycles=%0d addr=%h want 6/0/03", r, w, a); end
    total++; if (io_wrdata !== 8'hA5 || io_rd !== 1'b0) begin bad++; $display("FAIL io_load_acc acc=%h rd=%b want a5/0", io_wrdata, io_rd); end
    run(f_imm(8'h3E));
    run(f_sys(5'h04));
    exec_instr(f_op(3'd4, 5'd3), 2, 8'h00, r, w, a);
    total++; if (w !== 3 || r !== 0 || io_wrdata !== 8'h3E) begin bad++; $display("FAIL io_store wr_cycles=%0d rd_cycles=%0d data=%h want 3/0/3e", w, r, io_wrdata); end
    exec_instr(f_op(3'd5, 5'd3), 0, 8'h00, r, w, a);
    total++; if (io_wrdata !== 8'h77 || r !== 0) begin bad++; $display("FAIL io_prefix_once acc=%h rd_cycles=%0d want 77/0", io_wrdata, r); end
  endtask

  task automatic test_reg_off();
    logic [8:0] prog [10];
    prog = '{f_imm(8'h11), f_op(3'd4, 5'd1), f_imm(8'h22), f_op(3'd4, 5'd0),
             f_imm(8'h1F), f_op(3'd4, 5'd31), f_imm(8'h3C), f_op(3'd4, 5'd1),
             f_imm(8'h00), f_op(3'd4, 5'd0)};
    apply_reset();
    foreach (prog[i]) run(prog[i]);
    run(f_op(3'd5, 5'd1));
    total++; if (io_wrdata !== 8'h11) begin bad++; $display("FAIL bank_r1 acc=%h want 11", io_wrdata); end
    run(f_op(3'd5, 5'd0));
    total++; if (io_wrdata !== 8'h3C) begin bad++; $display("FAIL bank_r0 acc=%h want 3c", io_wrdata); end
    run(f_imm(8'hFE));
    run(f_sys(5'h12));
    total++; if (instr_addr !== 10'd14) begin bad++; $display("FAIL jmpc_not_taken pc=%h want 00e", instr_addr); end
    run(f_sys(5'h1A));
    total++; if (instr_addr !== 10'd12) begin bad++; $display("FAIL jmpnc_back pc=%h want 00c", instr_addr); end
  endtask

  task automatic test_halt();
    int r, w; logic [4:0] a;
    apply_reset();
    run(f_imm(8'h07));
    run(f_sys(5'h04));
    exec_instr(f_sys(5'h05), 0, 8'h00, r, w, a);
    repeat (4) @(posedge clk);
    #1;
    total++; if (halted !== 1'b1 || fault !== 2'b00 || instr_addr !== 10'd2 || io_wrdata !== 8'h07) begin bad++; $display("FAIL halt h=%b f=%b pc=%h acc=%h want 1/00/002/07", halted, fault, instr_addr, io_wrdata); end
    total++; if (io_rd !== 1'b0 || io_wr !== 1'b0) begin bad++; $display("FAIL halt_strobes rd=%b wr=%b want 0", io_rd, io_wr); end
  endtask

  function automatic logic [8:0] rand_instr();
    int k;
    k = $urandom_range(0, 99);
    if (k < 22)      return f_imm(8'($urandom));
    else if (k < 62) return f_op(3'($urandom_range(0, 6)), 5'($urandom));
    else if (k < 98) return f_sys(sys_tab[$urandom_range(0, 14)]);
    else             return f_sys(5'h05);
  endfunction

  task automatic test_random();
    int r, w, wn, exp_rd, exp_wr;
    logic [4:0] a, ra;
    logic [8:0] ins;
    logic [7:0] rdat;
    logic [2:0] op;
    bit io_exp;
    for (int p = 0; p < 40; p++) begin
      apply_reset();
      for (int s = 0; s < 120 && !m_halt; s++) begin
        ins = rand_instr();
        if (!ins[8]) begin
          op = ins[7:5]; ra = m_roff + ins[4:0];
          if ((op inside {3'd0, 3'd1, 3'd2, 3'd3, 3'd6} || (op == 3'd5 && !m_pre)) && !m_valid[ra])
            ins[7:5] = 3'd4;
        end
        io_exp = m_pre && !ins[8] && (ins[7:5] == 3'd4 || ins[7:5] == 3'd5);
        wn = $urandom_range(0, 3);
        rdat = 8'($urandom);
        exp_rd = (io_exp && ins[7:5] == 3'd5) ? wn + 1 : 0;
        exp_wr = (io_exp && ins[7:5] == 3'd4) ? wn + 1 : 0;
        exec_instr(ins, wn, rdat, r, w, a);
        total++; if (instr_addr !== m_pc || io_wrdata !== m_acc) begin bad++; $display("FAIL rand_state prog=%0d step=%0d ins=%h pc=%h acc=%h want %h/%h", p, s, ins, instr_addr, io_wrdata, m_pc, m_acc); end
        total++; if (zero !== m_zero || halted !== m_halt || fault !== m_fault) begin bad++; $display("FAIL rand_flags prog=%0d step=%0d ins=%h z=%b h=%b f=%b want %b/%b/%b", p, s, ins, zero, halted, fault, m_zero, m_halt, m_fault); end
        total++; if (r !== exp_rd || w !== exp_wr) begin bad++; $display("FAIL rand_io prog=%0d step=%0d ins=%h rd=%0d wr=%0d want %0d/%0d", p, s, ins, r, w, exp_rd, exp_wr); end
      end
      if (m_halt) begin
        repeat (3) @(posedge clk);
        #1;
        total++; if (instr_addr !== m_pc || halted !== 1'b1 || io_rd !== 1'b0) begin bad++; $display("FAIL rand_frozen prog=%0d pc=%h h=%b rd=%b want %h/1/0", p, instr_addr, halted, io_rd, m_pc); end
      end
    end
  endtask

  initial begin
    io_ready = 1'b0; io_rddata = '0;
    foreach (rom[i]) rom[i] = 9'h0E6;
    foreach (m_valid[i]) m_valid[i] = 0;
    foreach (m_rf[i]) m_rf[i] = '0;
    model_reset();
    test_reset();
    test_addc();
    test_call_ret();
    test_overflow();
    test_io();
    test_reg_off();
    test_halt();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
